// File: rtl/sim_btn_stim.sv
`timescale 1ns/1ps
// sim_btn_stim: plays queued button scripts (mask, bounce, hold) onto active-low lines, with a sticky cycle watchdog
module sim_btn_stim #(
   parameter int BTN_COUNT      = 6,
   parameter int HOLD_W         = 16,
   parameter int FIFO_DEPTH     = 8,
   parameter int BOUNCE_PERIOD  = 4,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [BTN_COUNT-1:0]        cmd_mask,
   input  logic [3:0]                  cmd_bounce,
   input  logic [HOLD_W-1:0]           cmd_hold,
   output logic [BTN_COUNT-1:0]        btn_n,
   output logic                        busy,
   output logic                        done,
   output logic                        timeout,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = BTN_COUNT + 4 + HOLD_W;
   localparam int BW = $clog2(BOUNCE_PERIOD + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [BW-1:0] BP_LOAD  = BW'(BOUNCE_PERIOD - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
   localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, PRESS, HOLD, RELEASE, GAP} state_t;

   state_t               state_q, state_d;
   logic [EW-1:0]        mem_q [FIFO_DEPTH];
   logic [EW-1:0]        mem_d [FIFO_DEPTH];
   logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
   logic [BTN_COUNT-1:0] mask_q, mask_d, btn_n_q, btn_n_d;
   logic [3:0]           n_q, n_d;
   logic [4:0]           seg_q, seg_d;
   logic [BW-1:0]        bp_q, bp_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic [GW-1:0]        gap_q, gap_d;
   logic [WW-1:0]        wd_q, wd_d;
   logic                 timeout_q, timeout_d, done_q, done_d;
   logic [EW-1:0]        head;
   logic [BTN_COUNT-1:0] h_mask;
   logic [3:0]           h_n;
   logic [HOLD_W-1:0]    h_hold;
   logic                 full, empty, push, pop, pressed;

   assign fifo_level = wr_q - rd_q;
   assign full       = fifo_level == LW'(FIFO_DEPTH);
   assign empty      = fifo_level == '0;
   assign cmd_ready  = !full && !timeout_q;
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state_q == IDLE) && !empty && !timeout_q;
   assign head       = mem_q[rd_q[AW-1:0]];
   assign h_mask     = head[EW-1 -: BTN_COUNT];
   assign h_n        = head[HOLD_W +: 4];
   assign h_hold     = head[HOLD_W-1:0];
   assign btn_n      = btn_n_q;
   assign done       = done_q;
   assign timeout    = timeout_q;
   assign busy       = !timeout_q && ((state_q != IDLE) || !empty);

   // Watchdog saturates one below the limit; reaching it latches timeout for good
   always_comb begin
      wd_d      = (wd_q == WD_MAX) ? wd_q : wd_q + WW'(1);
      timeout_d = timeout_q || (wd_d == WD_MAX);
   end

   // Queue storage and pointers; the timeout edge flushes everything queued
   always_comb begin
      mem_d = mem_q;
      if (push)
         mem_d[wr_q[AW-1:0]] = {cmd_mask, cmd_bounce, cmd_hold};
      wr_d = timeout_d ? '0 : wr_q + LW'(push);
      rd_d = timeout_d ? '0 : rd_q + LW'(pop);
   end

   // Next-state logic: segment counter runs 2N-1..0, bounce counter paces each segment
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      n_d     = n_q;
      seg_d   = seg_q;
      bp_d    = bp_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE:
            if (pop) begin
               state_d = (h_n == 4'd0) ? HOLD : PRESS;
               mask_d  = h_mask;
               n_d     = h_n;
               seg_d   = {h_n, 1'b0} - 5'd1;
               bp_d    = BP_LOAD;
               hold_d  = (h_hold == '0) ? '0 : h_hold - HOLD_W'(1);
            end
         PRESS, RELEASE:
            if (bp_q != '0)
               bp_d = bp_q - BW'(1);
            else begin
               bp_d = BP_LOAD;
               if (seg_q != 5'd0)
                  seg_d = seg_q - 5'd1;
               else begin
                  state_d = (state_q == PRESS) ? HOLD : GAP;
                  gap_d   = GAP_LOAD;
               end
            end
         HOLD:
            if (hold_q != '0)
               hold_d = hold_q - HOLD_W'(1);
            else begin
               state_d = (n_q == 4'd0) ? GAP : RELEASE;
               seg_d   = {n_q, 1'b0} - 5'd1;
               bp_d    = BP_LOAD;
               gap_d   = GAP_LOAD;
            end
         GAP:
            if (gap_q != '0)
               gap_d = gap_q - GW'(1);
            else
               state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (timeout_d)
         state_d = IDLE;
   end

   // Output decode: odd segment index is the first segment, pressed in PRESS, released in RELEASE
   always_comb begin
      pressed = (state_q == HOLD) || (state_q == PRESS && seg_q[0]) || (state_q == RELEASE && !seg_q[0]);
      btn_n_d = (pressed && !timeout_d) ? ~mask_q : '1;
      done_d  = (state_q == GAP) && (gap_q == '0) && !timeout_d;
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mask_q  <= '0;
         n_q     <= '0;
         seg_q   <= '0;
         bp_q    <= '0;
         hold_q  <= '0;
         gap_q   <= '0;
         btn_n_q <= '1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         n_q     <= n_d;
         seg_q   <= seg_d;
         bp_q    <= bp_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         btn_n_q <= btn_n_d;
         done_q  <= done_d;
      end
   end

   // Queue pointers and watchdog
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q      <= '0;
         rd_q      <= '0;
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

   // Queue storage needs no reset; pointers define validity
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: tb/tb_sim_btn_stim.sv
`timescale 1ns/1ps
// tb_sim_btn_stim: directed scripts against a waveform-level model of the button player
module tb_sim_btn_stim;
   localparam int BP = 4, GAP = 16, DEPTH = 8;

   typedef struct packed {logic [5:0] m; logic [3:0] n; logic [15:0] h;} cmd_t;

   logic        clk = 1'b0, rst = 1'b1, valid_a = 1'b0, valid_b = 1'b0;
   logic [5:0]  mask = '0;
   logic [3:0]  bnc = '0;
   logic [15:0] hold = '0;
   logic        ready_a, busy_a, done_a, to_a, ready_b, busy_b, done_b, to_b;
   logic [5:0]  btn_a, btn_b;
   logic [3:0]  lvl_a, lvl_b;
   int          n_cmp = 0, n_bad = 0, ec = 0;

   always #5 clk = ~clk;
   always @(posedge clk) ec <= ec + 1;

   sim_btn_stim u_a (
      .clk(clk), .rst(rst), .cmd_valid(valid_a), .cmd_ready(ready_a), .cmd_mask(mask),
      .cmd_bounce(bnc), .cmd_hold(hold), .btn_n(btn_a), .busy(busy_a), .done(done_a),
      .timeout(to_a), .fifo_level(lvl_a)
   );

   sim_btn_stim #(.TIMEOUT_CYCLES(200)) u_b (
      .clk(clk), .rst(rst), .cmd_valid(valid_b), .cmd_ready(ready_b), .cmd_mask(mask),
      .cmd_bounce(bnc), .cmd_hold(hold), .btn_n(btn_b), .busy(busy_b), .done(done_b),
      .timeout(to_b), .fifo_level(lvl_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, ec);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Model: queue of accepted commands, and the per-edge output waveform of the command playing
   cmd_t       mq[$];
   logic [6:0] wave[$];
   logic       s_rst = 1'b0, s_v = 1'b0, have = 1'b0;
   cmd_t       s_cmd;
   logic [5:0] e_btn;
   logic       e_done;

   task automatic expand(input cmd_t c);
      int hc;
      hc = (c.h == 16'd0) ? 1 : int'(c.h);
      for (int s = 0; s < 2 * int'(c.n); s++)
         for (int i = 0; i < BP; i++) wave.push_back({(s % 2 == 0) ? ~c.m : 6'h3F, 1'b0});
      for (int i = 0; i < hc; i++) wave.push_back({~c.m, 1'b0});
      for (int s = 0; s < 2 * int'(c.n); s++)
         for (int i = 0; i < BP; i++) wave.push_back({(s % 2 == 0) ? 6'h3F : ~c.m, 1'b0});
      for (int i = 0; i < GAP; i++) wave.push_back({6'h3F, i == GAP - 1});
   endtask

   always @(posedge clk) begin
      s_rst <= rst;
      s_v   <= valid_a;
      s_cmd <= {mask, bnc, hold};
   end

   always @(negedge clk) begin
      logic acc, act;
      if (s_rst) begin
         mq.delete();
         wave.delete();
         e_btn  = 6'h3F;
         e_done = 1'b0;
         have   = 1'b1;
      end else if (have) begin
         acc = s_v && (mq.size() < DEPTH);
         act = wave.size() != 0;
         {e_btn, e_done} = act ? wave.pop_front() : 7'h7E;
         if (!act && mq.size() != 0) expand(mq.pop_front());
         if (acc) mq.push_back(s_cmd);
      end
      if (have) begin
         chk("a_btn_n", 32'(btn_a), 32'(e_btn));
         chk("a_done", 32'(done_a), 32'(e_done));
         chk("a_level", 32'(lvl_a), 32'(mq.size()));
         chk("a_ready", 32'(ready_a), 32'(mq.size() < DEPTH));
         chk("a_busy", 32'(busy_a), 32'(wave.size() != 0 || mq.size() != 0));
         chk("a_timeout", 32'(to_a), 32'd0);
      end
   end

   task automatic push(input logic [5:0] m, input logic [3:0] n, input logic [15:0] h, output int t);
      mask = m; bnc = n; hold = h; valid_a = 1'b1;
      t = ec + 1;
      step();
      valid_a = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL global_time_limit: run did not finish");
      $fatal(1, "time limit");
   end

   logic [5:0] m4 [9];

   initial begin
      int t, lows, first, last, other, dn, de;
      m4 = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h00, 6'h03, 6'h05, 6'h06};
      // T1 reset
      repeat (3) step();
      rst = 1'b0;
      chk("t1_btn", 32'(btn_a), 32'h3F);
      chk("t1_ready", 32'(ready_a), 32'd1);
      chk("t1_busy", 32'(busy_a), 32'd0);
      chk("t1_level", 32'(lvl_a), 32'd0);
      chk("t1_b_btn", 32'(btn_b), 32'h3F);
      repeat (3) step();
      chk("t1_hold_btn", 32'(btn_a), 32'h3F);
      chk("t1_hold_level", 32'(lvl_a), 32'd0);
      // T2 clean press
      push(6'h01, 4'd0, 16'd10, t);
      lows = 0; first = -1; dn = 0; de = -1;
      repeat (40) begin
         step();
         if (btn_a == 6'h3E) begin lows++; if (first < 0) first = ec; end
         if (done_a) begin dn++; de = ec; end
      end
      chk("t2_low_cycles", 32'(lows), 32'd10);
      chk("t2_first_low", 32'(first), 32'(t + 2));
      chk("t2_done_count", 32'(dn), 32'd1);
      chk("t2_done_edge", 32'(de), 32'(t + 27));
      // T3 bounce
      push(6'h20, 4'd2, 16'd5, t);
      lows = 0; first = -1; last = -1; other = 0; dn = 0; de = -1;
      repeat (60) begin
         step();
         if (!btn_a[5]) begin lows++; last = ec; if (first < 0) first = ec; end
         if (btn_a[4:0] != 5'h1F) other++;
         if (done_a) begin dn++; de = ec; end
      end
      chk("t3_low_cycles", 32'(lows), 32'd21);
      chk("t3_first_low", 32'(first), 32'(t + 2));
      chk("t3_last_low", 32'(last), 32'(t + 38));
      chk("t3_other_bits", 32'(other), 32'd0);
      chk("t3_done_count", 32'(dn), 32'd1);
      chk("t3_done_edge", 32'(de), 32'(t + 54));
      // T4 queue full while cmd0 holds
      push(6'h01, 4'd0, 16'd30, t);
      step();
      for (int i = 0; i < 9; i++) begin
         mask = m4[i]; bnc = 4'(i % 2); hold = 16'd2; valid_a = 1'b1;
         step();
      end
      valid_a = 1'b0;
      chk("t4_level_full", 32'(lvl_a), 32'd8);
      chk("t4_ready_low", 32'(ready_a), 32'd0);
      dn = 0;
      for (int i = 0; i < 2000; i++) begin
         step();
         if (done_a) dn++;
         if (!busy_a) break;
      end
      chk("t4_done_count", 32'(dn), 32'd9);
      chk("t4_level_empty", 32'(lvl_a), 32'd0);
      chk("t4_idle", 32'(busy_a), 32'd0);
      // T6 reset mid-HOLD with 3 queued
      push(6'h01, 4'd0, 16'd50, t);
      push(6'h02, 4'd0, 16'd5, t);
      push(6'h04, 4'd1, 16'd5, t);
      push(6'h08, 4'd0, 16'd5, t);
      repeat (5) step();
      chk("t6_pressed", 32'(btn_a), 32'h3E);
      chk("t6_queued", 32'(lvl_a), 32'd3);
      rst = 1'b1;
      step();
      chk("t6_btn", 32'(btn_a), 32'h3F);
      chk("t6_level", 32'(lvl_a), 32'd0);
      chk("t6_timeout", 32'(to_a), 32'd0);
      chk("t6_busy", 32'(busy_a), 32'd0);
      // T5 watchdog on the 200-cycle instance
      step();
      rst = 1'b0;
      mask = 6'h01; bnc = 4'd0; hold = 16'd1000;
      for (int e = 1; e <= 230; e++) begin
         valid_b = (e <= 2) || (e >= 210 && e <= 214);
         step();
         chk("t5_btn", 32'(btn_b), (e >= 3 && e < 199) ? 32'h3E : 32'h3F);
         chk("t5_timeout", 32'(to_b), 32'(e >= 199));
         chk("t5_level", 32'(lvl_b), 32'(e < 199));
         chk("t5_ready", 32'(ready_b), 32'(e < 199));
         chk("t5_busy", 32'(busy_b), 32'(e < 199));
         chk("t5_done", 32'(done_b), 32'd0);
      end
      valid_b = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
